// File: rtl/game_master_fsm_multi_target.sv
// Game master for N target sprites and one torpedo: shot budget, hit mask, saturating score.
// Optional: GAME_MASTER_FIRST_SHOT_BONUS_EN doubles the points of hits made with the round's first torpedo.
module game_master_fsm_multi_target #(
   parameter int N_TARGETS = 2,
   parameter int N_SHOTS   = 3,
   parameter int SCORE_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 key,
   output logic [N_TARGETS-1:0] sprite_target_write_xy,
   output logic [N_TARGETS-1:0] sprite_target_write_dxy,
   output logic [N_TARGETS-1:0] sprite_target_enable_update,
   output logic                 sprite_torpedo_write_xy,
   output logic                 sprite_torpedo_write_dxy,
   output logic                 sprite_torpedo_enable_update,
   input  logic [N_TARGETS-1:0] sprite_target_within_screen,
   input  logic                 sprite_torpedo_within_screen,
   input  logic [N_TARGETS-1:0] collision,
   output logic                 end_of_game_timer_start,
   input  logic                 end_of_game_timer_running,
   output logic                 game_won,
   output logic [N_TARGETS-1:0] hit_mask,
   output logic [3:0]           shots_left,
   output logic [SCORE_W-1:0]   score
);
   typedef enum logic [4:0] {
      S_START  = 5'b00001,
      S_AIM    = 5'b00010,
      S_SHOOT  = 5'b00100,
      S_RELOAD = 5'b01000,
      S_END    = 5'b10000
   } state_t;

   state_t               r_state, w_nxt;
   logic                 r_key_prev, r_init;
   logic [N_TARGETS-1:0] w_alive, w_new_hit, w_hit_upd, w_hit_nxt;
   logic                 w_fire, w_lost, w_all_hit;
   logic [3:0]           w_cnt;
   logic [4:0]           w_add;
   logic [SCORE_W+4:0]   w_sum;
   logic [SCORE_W-1:0]   w_score_upd;

   function automatic logic [3:0] popcnt(input logic [N_TARGETS-1:0] v);
      popcnt = '0;
      for (int i = 0; i < N_TARGETS; i++) popcnt = popcnt + 4'(v[i]);
   endfunction

   assign w_fire      = key & ~r_key_prev;
   assign w_alive     = ~hit_mask;
   assign w_new_hit   = collision & w_alive;
   assign w_lost      = |(w_alive & ~sprite_target_within_screen & ~w_new_hit);
   assign w_hit_upd   = hit_mask | w_new_hit;
   assign w_all_hit   = &w_hit_upd;
   assign w_hit_nxt   = (r_state == S_SHOOT) ? w_hit_upd : hit_mask;
   assign w_cnt       = popcnt(w_new_hit);
`ifdef GAME_MASTER_FIRST_SHOT_BONUS_EN
   assign w_add = (shots_left == 4'(N_SHOTS - 1)) ? {w_cnt, 1'b0} : {1'b0, w_cnt};
`else
   assign w_add = {1'b0, w_cnt};
`endif
   assign w_sum       = (SCORE_W+5)'(score) + (SCORE_W+5)'(w_add);
   assign w_score_upd = (|w_sum[SCORE_W+4:SCORE_W]) ? '1 : w_sum[SCORE_W-1:0];

   // r_init holds off the first START cycle so the load pulses are seen after reset.
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_START:  w_nxt = r_init ? S_AIM : S_START;
         S_AIM: begin
            if (w_lost)                             w_nxt = S_END;
            else if (w_fire && (shots_left != 4'd0)) w_nxt = S_SHOOT;
         end
         S_SHOOT: begin
            if (w_all_hit)                                     w_nxt = S_END;
            else if (w_lost)                                   w_nxt = S_END;
            else if ((|w_new_hit) || !sprite_torpedo_within_screen) w_nxt = S_RELOAD;
         end
         S_RELOAD: w_nxt = (shots_left != 4'd0) ? S_AIM : S_END;
         // timer_start is high only in the first END cycle, so it doubles as that marker
         S_END:    if (!end_of_game_timer_start && !end_of_game_timer_running) w_nxt = S_START;
         default:  w_nxt = S_START;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state                      <= S_START;
         r_key_prev                   <= 1'b0;
         r_init                       <= 1'b0;
         sprite_target_write_xy       <= '0;
         sprite_target_write_dxy      <= '0;
         sprite_target_enable_update  <= '0;
         sprite_torpedo_write_xy      <= 1'b0;
         sprite_torpedo_write_dxy     <= 1'b0;
         sprite_torpedo_enable_update <= 1'b0;
         end_of_game_timer_start      <= 1'b0;
         game_won                     <= 1'b0;
         hit_mask                     <= '0;
         shots_left                   <= '0;
         score                        <= '0;
      end else begin
         r_state                      <= w_nxt;
         r_key_prev                   <= key;
         r_init                       <= 1'b1;
         sprite_target_write_xy       <= '0;
         sprite_target_write_dxy      <= '0;
         sprite_target_enable_update  <= '0;
         sprite_torpedo_write_xy      <= 1'b0;
         sprite_torpedo_write_dxy     <= 1'b0;
         sprite_torpedo_enable_update <= 1'b0;
         end_of_game_timer_start      <= 1'b0;
         if (r_state == S_SHOOT) begin
            hit_mask <= w_hit_upd;
            score    <= w_score_upd;
         end
         case (w_nxt)
            S_START: begin
               sprite_target_write_xy  <= '1;
               sprite_target_write_dxy <= '1;
               sprite_torpedo_write_xy <= 1'b1;
               shots_left              <= 4'(N_SHOTS);
               hit_mask                <= '0;
               game_won                <= 1'b0;
            end
            S_AIM: sprite_target_enable_update <= ~w_hit_nxt;
            S_SHOOT: begin
               sprite_target_enable_update  <= ~w_hit_nxt;
               sprite_torpedo_enable_update <= 1'b1;
               if (r_state != S_SHOOT) begin
                  sprite_torpedo_write_dxy <= 1'b1;
                  shots_left               <= shots_left - 4'd1;
               end
            end
            S_RELOAD: begin
               sprite_torpedo_write_xy     <= 1'b1;
               sprite_target_enable_update <= ~w_hit_nxt;
            end
            S_END: begin
               if (r_state != S_END) end_of_game_timer_start <= 1'b1;
               if ((r_state == S_SHOOT) && w_all_hit) game_won <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_game_master_fsm_multi_target.sv
// Directed bench for game_master_fsm_multi_target with hand-computed expectations.
module tb_game_master_fsm_multi_target;
`ifdef GAME_MASTER_FIRST_SHOT_BONUS_EN
   localparam int BF = 2;
`else
   localparam int BF = 1;
`endif
   logic       clk = 1'b0, reset_n = 1'b0, key = 1'b1;
   logic [1:0] tgt_wxy, tgt_wdxy, tgt_en, tgt_ws, coll, hit;
   logic       trp_wxy, trp_wdxy, trp_en, trp_ws, t_start, t_run, won;
   logic [3:0] shots;
   logic [7:0] score;
   int         n_chk = 0, n_fail = 0, exp_score = 0;

   game_master_fsm_multi_target #(.N_TARGETS(2), .N_SHOTS(3), .SCORE_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .key(key),
      .sprite_target_write_xy(tgt_wxy), .sprite_target_write_dxy(tgt_wdxy),
      .sprite_target_enable_update(tgt_en),
      .sprite_torpedo_write_xy(trp_wxy), .sprite_torpedo_write_dxy(trp_wdxy),
      .sprite_torpedo_enable_update(trp_en),
      .sprite_target_within_screen(tgt_ws), .sprite_torpedo_within_screen(trp_ws),
      .collision(coll), .end_of_game_timer_start(t_start),
      .end_of_game_timer_running(t_run), .game_won(won), .hit_mask(hit),
      .shots_left(shots), .score(score));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic press();
      key = 1'b0; tick();
      key = 1'b1; tick();
      key = 1'b0;
   endtask

   // From a START cycle: one round won by a double hit on the first torpedo, back to START.
   task automatic dbl_round();
      tick();
      press();
      coll = 2'b11; tick();
      coll = 2'b00; tick(); tick();
      exp_score = (exp_score + 2*BF > 255) ? 255 : exp_score + 2*BF;
   endtask

   initial begin
      tgt_ws = 2'b11; trp_ws = 1'b1; coll = 2'b00; t_run = 1'b0;
      #2;
      chk("rst_score", 32'(score), 0);
      chk("rst_outs", {tgt_wxy, tgt_wdxy, tgt_en, trp_wxy, trp_wdxy, trp_en, t_start, won}, 0);
      chk("rst_shots", 32'(shots), 0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;

      // startup with key held
      tick();
      chk("start_wxy", {tgt_wxy, tgt_wdxy, trp_wxy}, 5'b11111);
      chk("start_shots", 32'(shots), 3);
      tick();
      chk("aim_en", 32'(tgt_en), 2'b11);
      chk("aim_nopulse", {tgt_wxy, trp_wxy}, 0);
      tick();
      chk("held_nofire", {trp_en, trp_wdxy}, 0);

      // first shot: hit target 0 while it also leaves the screen
      press();
      chk("shoot1_entry", {trp_wdxy, trp_en}, 2'b11);
      chk("shoot1_shots", 32'(shots), 2);
      coll = 2'b01; tgt_ws = 2'b10; tick();
      coll = 2'b00; tgt_ws = 2'b11;
      chk("hit0_mask", 32'(hit), 2'b01);
      chk("hit0_score", 32'(score), BF);
      chk("hit0_reload", {trp_wxy, t_start}, 2'b10);
      exp_score = BF;
      tick();
      chk("aim2_en", 32'(tgt_en), 2'b10);
      chk("aim2_shots", 32'(shots), 2);

      // second shot: re-hit of target 0 is ignored, then target 1 wins
      press();
      chk("shoot2_shots", 32'(shots), 1);
      coll = 2'b01; tick();
      chk("rehit_score", 32'(score), exp_score);
      chk("rehit_stay", {trp_wxy, trp_wdxy, trp_en}, 3'b001);
      coll = 2'b10; tick();
      coll = 2'b00;
      exp_score = exp_score + 1;
      chk("win_mask", 32'(hit), 2'b11);
      chk("win_score", 32'(score), exp_score);
      chk("win_flags", {won, t_start, trp_en}, 3'b110);
      tick();
      chk("end_hold", {won, t_start}, 2'b10);
      tick();
      chk("restart_wxy", 32'(tgt_wxy), 2'b11);
      chk("restart_clr", {won, hit}, 0);
      chk("restart_score", 32'(score), exp_score);

      // three misses exhaust the budget
      tick();
      for (int i = 0; i < 3; i++) begin
         press();
         chk("miss_shots", 32'(shots), 32'(2 - i));
         trp_ws = 1'b0; tick();
         chk("miss_reload", 32'(trp_wxy), 1);
         trp_ws = 1'b1; tick();
         if (i < 2) chk("miss_aim", 32'(tgt_en), 2'b11);
         else chk("miss_end", {t_start, won, trp_en}, 3'b100);
      end
      tick(); tick();
      chk("miss_restart", 32'(tgt_wxy), 2'b11);

      // target 1 escapes in AIM; timer holds END
      tick();
      tgt_ws = 2'b01; t_run = 1'b1; tick();
      chk("lost_end", {t_start, tgt_en}, 3'b100);
      tgt_ws = 2'b11;
      repeat (10) tick();
      chk("timer_hold", {tgt_wxy, tgt_en, t_start, won}, 0);
      t_run = 1'b0; tick();
      chk("timer_release", 32'(tgt_wxy), 2'b11);

      // double hit in one SHOOT cycle
      dbl_round();
      chk("dbl_score", 32'(score), exp_score);

      // saturation
      for (int r = 0; r < 200 && exp_score < 255; r++) dbl_round();
      chk("sat_reach", 32'(score), 255);
      dbl_round();
      chk("sat_hold", 32'(score), 255);

      // asynchronous reset in the middle of SHOOT
      tick();
      press();
      chk("pre_rst_shoot", 32'(trp_en), 1);
      #3 reset_n = 1'b0;
      #1;
      chk("mid_rst_score", 32'(score), 0);
      chk("mid_rst_outs", {tgt_en, trp_en, trp_wdxy, won, hit}, 0);
      chk("mid_rst_shots", 32'(shots), 0);
      #10 reset_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/game_master_fsm_multi_target.md
Name: game_master_fsm_multi_target

Overview:
- Next-generation game master controlling N target sprites and one torpedo, with a limited shot budget, a per-target hit mask and a saturating score.
- Sits between the key input, the sprite engines, collision detection and the end-of-game timer.
- Replaces the single-target master.
- Generalises to N targets, rising-edge firing, multi-shot rounds with torpedo reload, and win-on-all-hit.

Parameters:
- N_TARGETS, 2, number of target sprites (1..8)
- N_SHOTS, 3, torpedoes per round (1..15)
- SCORE_W, 8, score counter width

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- key  input  1  fire button, level
- sprite_target_write_xy  output  N_TARGETS  load start position per target
- sprite_target_write_dxy  output  N_TARGETS  load velocity per target
- sprite_target_enable_update  output  N_TARGETS  per-target motion enable
- sprite_torpedo_write_xy  output  1  load torpedo start position
- sprite_torpedo_write_dxy  output  1  load torpedo velocity
- sprite_torpedo_enable_update  output  1  torpedo motion enable
- sprite_target_within_screen  input  N_TARGETS  per-target on-screen flag
- sprite_torpedo_within_screen  input  1  torpedo on-screen flag
- collision  input  N_TARGETS  torpedo-target collision per target
- end_of_game_timer_start  output  1  one-cycle start pulse
- end_of_game_timer_running  input  1  timer busy
- game_won  output  1  round won
- hit_mask  output  N_TARGETS  targets hit this round
- shots_left  output  4  remaining torpedoes
- score  output  SCORE_W  cumulative score

Behaviour:
- Reset (reset_n low, async):
  - state = START.
  - All outputs 0.
  - key_prev = 0.
- One-hot states: START, AIM, SHOOT, RELOAD, END.
- Next state is combinational. All outputs are registered and decoded from next state, so each output is valid in the first cycle of its state.
- fire = key & ~key_prev; only sampled in AIM.
- alive = ~hit_mask.
- new_hit = collision & alive.
- lost = |(alive & ~sprite_target_within_screen & ~new_hit).
- START:
  - Pulse all target write_xy/write_dxy and torpedo write_xy.
  - shots_left = N_SHOTS, hit_mask = 0, game_won = 0.
  - Go to AIM next cycle.
- AIM:
  - target enable_update = alive.
  - lost -> END.
  - Else if fire and shots_left != 0 -> SHOOT.
  - Else stay in AIM.
- SHOOT entry: torpedo write_dxy pulses one cycle; shots_left decrements.
- SHOOT:
  - Torpedo update and alive-target update enabled.
  - hit_mask |= new_hit.
  - Score adds popcount(new_hit), saturating at 2^SCORE_W-1.
  - Hit mask becomes all ones -> END with game_won = 1.
  - Else lost -> END.
  - Else any new_hit or torpedo off screen -> RELOAD.
  - Else stay in SHOOT.
- RELOAD (one cycle):
  - Pulse torpedo write_xy.
  - shots_left != 0 -> AIM, else END (game_won stays 0).
- END entry: end_of_game_timer_start pulses exactly one cycle; all enables 0.
- END:
  - Leave only when not in the first END cycle and end_of_game_timer_running = 0. Then go to START.
  - game_won, hit_mask and score hold.
- Simultaneous events:
  - A hit has priority over leaving the screen for the same target.
  - Collision on an already-hit target is ignored: no score, no reload.
  - Multiple hits in one cycle all count.
- Key held across START or RELOAD does not fire; a new rising edge is needed.
- Reset mid-round returns to START-pending immediately; the score is cleared.
- score is cleared only by reset, never at START.

Optional Feature:
- Macro: GAME_MASTER_FIRST_SHOT_BONUS_EN.
- Defined: a hit scored with the first torpedo of the round (shots_left == N_SHOTS-1 in SHOOT) adds 2 per target instead of 1, still saturating.
- Undefined: every hit adds 1; no extra logic.

Test Plan:
- Reset release with key held high -> START pulses write_xy on all N_TARGETS=2; AIM reached; no SHOOT until key drops and rises again.
- Fire, collision[0] asserted -> hit_mask=01, score=1, RELOAD, AIM, shots_left=2; fire, collision[1] -> hit_mask=11, score=2, game_won=1, single timer_start pulse.
- Three shots, torpedo leaves screen each time -> shots_left 2,1,0; after third RELOAD -> END, game_won=0.
- In AIM, target 1 alive and within_screen[1]=0 -> END in next cycle; timer_running held 1 for 10 cycles -> END held; drops -> START.
- collision=11 in one SHOOT cycle -> score+2, game_won=1; with GAME_MASTER_FIRST_SHOT_BONUS_EN on the first shot -> score+4.
- score at 255 plus a hit -> stays 255; reset_n low mid-SHOOT -> all outputs 0 asynchronously.
